// File: rtl/ide_pkg.sv
// ide_pkg: shared definitions for the multi-sector IDE/ATA PIO controller.
//   - ATA task-file register addresses as seen by the register-access engine
//   - STATUS register bit positions
//   - ATA command codes and the device-control value written during setup
//   - err_code values reported on the error output
//   - controller state enum
package ide_pkg;

  localparam logic [4:0] ATA_DATA    = 5'b10000;
  localparam logic [4:0] ATA_SECCNT  = 5'b10010;
  localparam logic [4:0] ATA_SECNUM  = 5'b10011;
  localparam logic [4:0] ATA_CYLLOW  = 5'b10100;
  localparam logic [4:0] ATA_CYLHIGH = 5'b10101;
  localparam logic [4:0] ATA_DRVHEAD = 5'b10110;
  localparam logic [4:0] ATA_STATUS  = 5'b10111;
  localparam logic [4:0] ATA_COMMAND = 5'b10111;
  localparam logic [4:0] ATA_ALTSTAT = 5'b01110;
  localparam logic [4:0] ATA_DEVCTRL = 5'b01110;

  localparam int ST_BSY  = 7;
  localparam int ST_DRDY = 6;
  localparam int ST_DWF  = 5;
  localparam int ST_DRQ  = 3;
  localparam int ST_ERR  = 0;

  localparam logic [7:0] CMD_READ    = 8'h20;
  localparam logic [7:0] CMD_WRITE   = 8'h30;
  // nIEN set: the controller polls, the device must not raise INTRQ
  localparam logic [7:0] DEVCTRL_VAL = 8'h02;

  localparam logic [2:0] ERRC_NONE  = 3'd0;
  localparam logic [2:0] ERRC_PARAM = 3'd1;
  localparam logic [2:0] ERRC_DEV   = 3'd2;
  localparam logic [2:0] ERRC_TMO   = 3'd3;
  localparam logic [2:0] ERRC_DWF   = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_DEVCTRL,
    S_SECCNT,
    S_SECNUM,
    S_CYLLOW,
    S_CYLHIGH,
    S_DRVHEAD,
    S_COMMAND,
    S_ALT_STATUS,
    S_POLL_DRQ,
    S_XFER,
    S_SECT_END,
    S_FINAL,
    S_DONE,
    S_ERR
  } ide_state_e;

endpackage

// File: rtl/ide_timer.sv
// ide_timer: poll-state watchdog for ide_disk_multi.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : reload the down-counter with TMO_CYC-1 (held while not polling)
//   enable_i   : count one cycle per clock while polling
//   expire_o   : high in the TMO_CYC-th enabled cycle after the last load
module ide_timer #(
  parameter logic [23:0] TMO_CYC = 24'd5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [23:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= TMO_CYC - 24'd1;
    end else if (enable_i && (cnt_q != 24'd0)) begin
      cnt_q <= cnt_q - 24'd1;
    end
  end

  assign expire_o = enable_i && !load_i && (cnt_q == 24'd0);

endmodule

// File: rtl/ide_disk_multi.sv
// ide_disk_multi: multi-sector ATA PIO read/write sequencer.
// Drives a register-access engine (ata_rd/ata_wr level requests held until
// ata_done) and a word buffer with one-cycle read latency.
//
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   lba, sect_cnt        : start LBA (28b), sector count (1..MAX_SECT)
//   read_req, write_req  : start request, sampled only in IDLE
//   busy, done, error,
//   err_code             : status; done is a one-cycle pulse, error is sticky
//   buffer_*             : word buffer port, buffer_addr is the word counter
//   ata_*                : register-access engine handshake
//
// Build option: define IDE_DISK_TIMEOUT_EN to add a TMO_CYC-cycle watchdog on
// every poll state (err_code 3); without it polling never times out.
//
// state        | meaning
// IDLE         | waiting for a request
// WAIT_RDY     | poll STATUS until BSY=0, DRDY=1
// DEVCTRL..    |
//   COMMAND    | task-file setup writes, then the command byte
// ALT_STATUS   | dummy ALT_STATUS read (400 ns settle) before each sector
// POLL_DRQ     | poll STATUS for DRQ, ERR or DWF
// XFER         | move 256 words of one sector
// SECT_END     | decrement remaining sectors
// FINAL        | ALT_STATUS then STATUS (until BSY=0), check ERR
// DONE / ERR   | one-cycle done pulse, back to IDLE
module ide_disk_multi
  import ide_pkg::*;
#(
  parameter int          DATA_W   = 12,
  parameter int          MAX_SECT = 8,
  parameter logic [23:0] TMO_CYC  = 24'd5000000,
  localparam int         BUF_AW   = $clog2(MAX_SECT*256)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [27:0]       lba,
  input  logic [7:0]        sect_cnt,
  input  logic              read_req,
  input  logic              write_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code,
  output logic [BUF_AW-1:0] buffer_addr,
  output logic              buffer_rd,
  output logic              buffer_wr,
  output logic [DATA_W-1:0] buffer_out,
  input  logic [DATA_W-1:0] buffer_in,
  output logic              ata_rd,
  output logic              ata_wr,
  output logic [4:0]        ata_addr,
  output logic [15:0]       ata_in,
  input  logic [15:0]       ata_out,
  input  logic              ata_done
);

  localparam logic [8:0] MAX_SECT_L = 9'(MAX_SECT);

  ide_state_e        state_q;
  logic [27:0]       lba_q;
  logic [7:0]        sect_cnt_q;
  logic              dir_wr_q;
  logic [7:0]        rem_q;
  logic [BUF_AW-1:0] word_cnt_q;
  logic [7:0]        wic_q;      // word within the current sector
  logic [1:0]        xph_q;      // per-word phase inside XFER
  logic              fin_stat_q; // FINAL: 0 = ALT_STATUS read, 1 = STATUS read
  logic              busy_q, done_q, error_q;
  logic [2:0]        err_code_q;
  logic              ata_rd_q, ata_wr_q;
  logic [4:0]        ata_addr_q;
  logic [15:0]       ata_in_q;
  logic              buffer_rd_q, buffer_wr_q;
  logic [DATA_W-1:0] buffer_out_q;

  logic              acc_idle;
  logic              acc_done;
  logic [4:0]        setup_addr;
  logic [15:0]       setup_data;
  ide_state_e        setup_next;

  assign acc_idle = !ata_rd_q && !ata_wr_q;
  assign acc_done = (ata_rd_q || ata_wr_q) && ata_done;

  always_comb begin
    setup_addr = ATA_DEVCTRL;
    setup_data = {8'h00, DEVCTRL_VAL};
    setup_next = S_SECCNT;
    case (state_q)
      S_SECCNT: begin
        setup_addr = ATA_SECCNT;
        setup_data = {8'h00, sect_cnt_q};
        setup_next = S_SECNUM;
      end
      S_SECNUM: begin
        setup_addr = ATA_SECNUM;
        setup_data = {8'h00, lba_q[7:0]};
        setup_next = S_CYLLOW;
      end
      S_CYLLOW: begin
        setup_addr = ATA_CYLLOW;
        setup_data = {8'h00, lba_q[15:8]};
        setup_next = S_CYLHIGH;
      end
      S_CYLHIGH: begin
        setup_addr = ATA_CYLHIGH;
        setup_data = {8'h00, lba_q[23:16]};
        setup_next = S_DRVHEAD;
      end
      S_DRVHEAD: begin
        // LBA mode, device 0
        setup_addr = ATA_DRVHEAD;
        setup_data = {8'h00, 4'h4, lba_q[27:24]};
        setup_next = S_COMMAND;
      end
      S_COMMAND: begin
        setup_addr = ATA_COMMAND;
        setup_data = {8'h00, dir_wr_q ? CMD_WRITE : CMD_READ};
        setup_next = S_ALT_STATUS;
      end
      default: ;
    endcase
  end

`ifdef IDE_DISK_TIMEOUT_EN
  logic tmo_poll;
  logic tmo_expire;

  // Every poll state is entered from a non-poll state, so holding the
  // timer in load outside the poll states reloads it on each entry.
  assign tmo_poll = (state_q == S_WAIT_RDY) || (state_q == S_POLL_DRQ) ||
                    (state_q == S_FINAL);

  ide_timer #(.TMO_CYC(TMO_CYC)) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (!tmo_poll),
    .enable_i (tmo_poll),
    .expire_o (tmo_expire)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      lba_q        <= '0;
      sect_cnt_q   <= '0;
      dir_wr_q     <= 1'b0;
      rem_q        <= '0;
      word_cnt_q   <= '0;
      wic_q        <= '0;
      xph_q        <= '0;
      fin_stat_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERRC_NONE;
      ata_rd_q     <= 1'b0;
      ata_wr_q     <= 1'b0;
      ata_addr_q   <= '0;
      ata_in_q     <= '0;
      buffer_rd_q  <= 1'b0;
      buffer_wr_q  <= 1'b0;
      buffer_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (read_req || write_req) begin
            lba_q      <= lba;
            sect_cnt_q <= sect_cnt;
            rem_q      <= sect_cnt;
            dir_wr_q   <= write_req;
            word_cnt_q <= '0;
            wic_q      <= '0;
            xph_q      <= '0;
            fin_stat_q <= 1'b0;
            busy_q     <= 1'b1;
            if ((read_req && write_req) || (sect_cnt == 8'd0) ||
                ({1'b0, sect_cnt} > MAX_SECT_L)) begin
              state_q    <= S_ERR;
              error_q    <= 1'b1;
              err_code_q <= ERRC_PARAM;
              done_q     <= 1'b1;
            end else begin
              state_q    <= S_WAIT_RDY;
              error_q    <= 1'b0;
              err_code_q <= ERRC_NONE;
            end
          end
        end

        S_WAIT_RDY: begin
          if (acc_idle) begin
            ata_rd_q   <= 1'b1;
            ata_addr_q <= ATA_STATUS;
            ata_in_q   <= '0;
          end else if (acc_done) begin
            ata_rd_q <= 1'b0;
            if (!ata_out[ST_BSY] && ata_out[ST_DRDY]) state_q <= S_DEVCTRL;
          end
        end

        S_DEVCTRL, S_SECCNT, S_SECNUM, S_CYLLOW, S_CYLHIGH, S_DRVHEAD,
        S_COMMAND: begin
          if (acc_idle) begin
            ata_wr_q   <= 1'b1;
            ata_addr_q <= setup_addr;
            ata_in_q   <= setup_data;
          end else if (acc_done) begin
            ata_wr_q <= 1'b0;
            state_q  <= setup_next;
          end
        end

        S_ALT_STATUS: begin
          if (acc_idle) begin
            ata_rd_q   <= 1'b1;
            ata_addr_q <= ATA_ALTSTAT;
            ata_in_q   <= '0;
          end else if (acc_done) begin
            ata_rd_q <= 1'b0;
            state_q  <= S_POLL_DRQ;
          end
        end

        S_POLL_DRQ: begin
          if (acc_idle) begin
            ata_rd_q   <= 1'b1;
            ata_addr_q <= ATA_STATUS;
            ata_in_q   <= '0;
          end else if (acc_done) begin
            ata_rd_q <= 1'b0;
            if (ata_out[ST_ERR]) begin
              state_q    <= S_ERR;
              error_q    <= 1'b1;
              err_code_q <= ERRC_DEV;
              done_q     <= 1'b1;
            end else if (ata_out[ST_DWF]) begin
              state_q    <= S_ERR;
              error_q    <= 1'b1;
              err_code_q <= ERRC_DWF;
              done_q     <= 1'b1;
            end else if (!ata_out[ST_BSY] && ata_out[ST_DRQ]) begin
              state_q <= S_XFER;
              xph_q   <= 2'd0;
            end
          end
        end

        S_XFER: begin
          if (!dir_wr_q) begin
            // read: DATA access, then a one-cycle buffer write of the word
            case (xph_q)
              2'd0: begin
                ata_rd_q   <= 1'b1;
                ata_addr_q <= ATA_DATA;
                ata_in_q   <= '0;
                xph_q      <= 2'd1;
              end
              2'd1: begin
                if (acc_done) begin
                  ata_rd_q     <= 1'b0;
                  buffer_wr_q  <= 1'b1;
                  buffer_out_q <= ata_out[DATA_W-1:0];
                  xph_q        <= 2'd2;
                end
              end
              default: begin
                buffer_wr_q <= 1'b0;
                word_cnt_q  <= word_cnt_q + 1'b1;
                wic_q       <= wic_q + 8'd1;
                xph_q       <= 2'd0;
                if (wic_q == 8'hFF) state_q <= S_SECT_END;
              end
            endcase
          end else begin
            // write: buffer read, wait out its latency, then DATA access
            case (xph_q)
              2'd0: begin
                buffer_rd_q <= 1'b1;
                xph_q       <= 2'd1;
              end
              2'd1: begin
                buffer_rd_q <= 1'b0;
                xph_q       <= 2'd2;
              end
              2'd2: begin
                ata_wr_q   <= 1'b1;
                ata_addr_q <= ATA_DATA;
                ata_in_q   <= 16'(buffer_in);
                xph_q      <= 2'd3;
              end
              default: begin
                if (acc_done) begin
                  ata_wr_q   <= 1'b0;
                  word_cnt_q <= word_cnt_q + 1'b1;
                  wic_q      <= wic_q + 8'd1;
                  xph_q      <= 2'd0;
                  if (wic_q == 8'hFF) state_q <= S_SECT_END;
                end
              end
            endcase
          end
        end

        S_SECT_END: begin
          rem_q <= rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_q    <= S_FINAL;
            fin_stat_q <= 1'b0;
          end else begin
            state_q <= S_ALT_STATUS;
          end
        end

        S_FINAL: begin
          if (acc_idle) begin
            ata_rd_q   <= 1'b1;
            ata_addr_q <= fin_stat_q ? ATA_STATUS : ATA_ALTSTAT;
            ata_in_q   <= '0;
          end else if (acc_done) begin
            ata_rd_q <= 1'b0;
            if (!fin_stat_q) begin
              fin_stat_q <= 1'b1;
            end else if (!ata_out[ST_BSY]) begin
              done_q <= 1'b1;
              if (ata_out[ST_ERR]) begin
                state_q    <= S_ERR;
                error_q    <= 1'b1;
                err_code_q <= ERRC_DEV;
              end else begin
                state_q <= S_DONE;
              end
            end
          end
        end

        S_DONE, S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase

`ifdef IDE_DISK_TIMEOUT_EN
      if (tmo_expire) begin
        ata_rd_q   <= 1'b0;
        ata_wr_q   <= 1'b0;
        state_q    <= S_ERR;
        error_q    <= 1'b1;
        err_code_q <= ERRC_TMO;
        done_q     <= 1'b1;
      end
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign buffer_addr = word_cnt_q;
  assign buffer_rd   = buffer_rd_q;
  assign buffer_wr   = buffer_wr_q;
  assign buffer_out  = buffer_out_q;
  assign ata_rd      = ata_rd_q;
  assign ata_wr      = ata_wr_q;
  assign ata_addr    = ata_addr_q;
  assign ata_in      = ata_in_q;

endmodule

// File: tb/tb_ide_disk_multi.sv
// Directed bench for ide_disk_multi with a behavioural ATA register engine
// (ata_done one cycle after a request is seen) and a 1-cycle-latency buffer
// that returns its own address. DATA reads return {4'hF, idx ^ 12'h5A5}.
module tb_ide_disk_multi;
  import ide_pkg::*;

  localparam int DATA_W   = 12;
  localparam int MAX_SECT = 8;
  localparam int BUF_AW   = $clog2(MAX_SECT*256);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [27:0]       lba = '0;
  logic [7:0]        sect_cnt = '0;
  logic              read_req = 1'b0, write_req = 1'b0;
  logic              busy, done, error;
  logic [2:0]        err_code;
  logic [BUF_AW-1:0] buffer_addr;
  logic              buffer_rd, buffer_wr;
  logic [DATA_W-1:0] buffer_out;
  logic [DATA_W-1:0] buffer_in = '0;
  logic              ata_rd, ata_wr;
  logic [4:0]        ata_addr;
  logic [15:0]       ata_in;
  logic [15:0]       ata_out = '0;
  logic              ata_done = 1'b0;

  int n_pass = 0, n_total = 0;

  // model / monitor state
  bit   inject_err = 1'b0, stuck_bsy = 1'b0;
  int   rd_idx = 0, wr_idx = 0, exp_baddr = 0;
  int   n_bufwr = 0, n_bufrd = 0, bw_addr_bad = 0, bw_data_bad = 0;
  int   n_acc = 0, n_data_rd = 0, n_data_wr = 0, wdata_bad = 0;
  int   excl_bad = 0, n_done = 0;
  logic [7:0] last_reg [32];

  ide_disk_multi #(.DATA_W(DATA_W), .MAX_SECT(MAX_SECT), .TMO_CYC(24'd100)) dut (
    .clk(clk), .reset(reset), .lba(lba), .sect_cnt(sect_cnt),
    .read_req(read_req), .write_req(write_req),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .buffer_addr(buffer_addr), .buffer_rd(buffer_rd), .buffer_wr(buffer_wr),
    .buffer_out(buffer_out), .buffer_in(buffer_in),
    .ata_rd(ata_rd), .ata_wr(ata_wr), .ata_addr(ata_addr), .ata_in(ata_in),
    .ata_out(ata_out), .ata_done(ata_done)
  );

  always #5 clk = ~clk;

  // ATA register engine + buffer
  always @(posedge clk) begin
    if (!busy) rd_idx = 0;
    if ((ata_rd || ata_wr) && !ata_done) begin
      ata_done <= 1'b1;
      if (ata_rd && ata_addr == ATA_DATA) begin
        ata_out <= {4'hF, 12'(rd_idx) ^ 12'h5A5};
        rd_idx++;
      end else if (ata_rd) begin
        ata_out <= {8'h00, stuck_bsy ? 8'h80 :
                           (inject_err && rd_idx >= 256) ? 8'h51 : 8'h58};
      end
    end else begin
      ata_done <= 1'b0;
    end
    if (buffer_rd) buffer_in <= DATA_W'(buffer_addr);
  end

  // monitor
  always @(negedge clk) begin
    if (!busy) begin exp_baddr = 0; wr_idx = 0; end
    if (buffer_wr) begin
      n_bufwr++;
      if (buffer_addr !== BUF_AW'(exp_baddr)) bw_addr_bad++;
      if (buffer_out !== (12'(exp_baddr) ^ 12'h5A5)) bw_data_bad++;
      exp_baddr++;
    end
    if (buffer_rd) n_bufrd++;
    if ((ata_rd || ata_wr) && ata_done) begin
      n_acc++;
      if (ata_rd && ata_addr == ATA_DATA) n_data_rd++;
      if (ata_wr) begin
        if (ata_addr == ATA_DATA) begin
          if (ata_in !== 16'(wr_idx)) wdata_bad++;
          wr_idx++;
          n_data_wr++;
        end else begin
          last_reg[ata_addr] = ata_in[7:0];
        end
      end
    end
    if (int'(buffer_rd) + int'(buffer_wr) + int'(ata_rd) + int'(ata_wr) > 1) excl_bad++;
    if (done) n_done++;
  end

  task automatic start_req(input logic rd, input logic wr, input logic [27:0] a,
                           input logic [7:0] c);
    @(negedge clk);
    lba = a; sect_cnt = c; read_req = rd; write_req = wr;
    @(negedge clk);
    read_req = 1'b0; write_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < budget) begin
      if (done) ok = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
  endtask

  task automatic test_reset();
    logic [53:0] outv;
    repeat (3) @(negedge clk);
    outv = {busy, done, error, err_code, buffer_addr, buffer_rd, buffer_wr,
            buffer_out, ata_rd, ata_wr, ata_addr, ata_in};
    n_total++;
    if (outv !== '0) $display("FAIL reset_outputs got=%h want=0", outv); else n_pass++;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", busy); else n_pass++;
    n_total++;
    if (n_acc !== 0) $display("FAIL idle_no_access got=%0d want=0", n_acc); else n_pass++;
  endtask

  task automatic test_read2();
    int b_bw, b_bwa, b_bwd, b_done, b_ex, cyc;
    bit ok;
    b_bw = n_bufwr; b_bwa = bw_addr_bad; b_bwd = bw_data_bad; b_done = n_done; b_ex = excl_bad;
    start_req(1'b1, 1'b0, 28'h0000123, 8'd2);
    n_total++;
    if (busy !== 1'b1) $display("FAIL rd_busy got=%b want=1", busy); else n_pass++;
    wait_done(20000, ok, cyc);
    n_total++;
    if (!ok) $display("FAIL rd_done_wait got=timeout want=done"); else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (n_bufwr - b_bw !== 512) $display("FAIL rd_bufwr_count got=%0d want=512", n_bufwr - b_bw); else n_pass++;
    n_total++;
    if (bw_addr_bad - b_bwa !== 0) $display("FAIL rd_bufwr_addr bad=%0d want=0", bw_addr_bad - b_bwa); else n_pass++;
    n_total++;
    if (bw_data_bad - b_bwd !== 0) $display("FAIL rd_bufwr_data bad=%0d want=0", bw_data_bad - b_bwd); else n_pass++;
    n_total++;
    if (n_done - b_done !== 1) $display("FAIL rd_done_pulses got=%0d want=1", n_done - b_done); else n_pass++;
    n_total++;
    if (error !== 1'b0 || err_code !== 3'd0) $display("FAIL rd_error got=%b/%0d want=0/0", error, err_code); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rd_busy_after got=%b want=0", busy); else n_pass++;
    n_total++;
    if (last_reg[5'h0E] !== 8'h02) $display("FAIL rd_devctrl got=%h want=02", last_reg[5'h0E]); else n_pass++;
    n_total++;
    if (last_reg[5'h12] !== 8'h02) $display("FAIL rd_seccnt got=%h want=02", last_reg[5'h12]); else n_pass++;
    n_total++;
    if (last_reg[5'h13] !== 8'h23) $display("FAIL rd_secnum got=%h want=23", last_reg[5'h13]); else n_pass++;
    n_total++;
    if (last_reg[5'h14] !== 8'h01) $display("FAIL rd_cyllow got=%h want=01", last_reg[5'h14]); else n_pass++;
    n_total++;
    if (last_reg[5'h15] !== 8'h00) $display("FAIL rd_cylhigh got=%h want=00", last_reg[5'h15]); else n_pass++;
    n_total++;
    if (last_reg[5'h16] !== 8'h40) $display("FAIL rd_drvhead got=%h want=40", last_reg[5'h16]); else n_pass++;
    n_total++;
    if (last_reg[5'h17] !== 8'h20) $display("FAIL rd_command got=%h want=20", last_reg[5'h17]); else n_pass++;
    n_total++;
    if (excl_bad - b_ex !== 0) $display("FAIL rd_exclusive viol=%0d want=0", excl_bad - b_ex); else n_pass++;
  endtask

  task automatic test_write1();
    int b_wr, b_wb, b_rd, b_ex, b_bw, cyc;
    bit ok;
    b_wr = n_data_wr; b_wb = wdata_bad; b_rd = n_bufrd; b_ex = excl_bad; b_bw = n_bufwr;
    start_req(1'b0, 1'b1, 28'h5ABCDEF, 8'd1);
    wait_done(20000, ok, cyc);
    n_total++;
    if (!ok) $display("FAIL wr_done_wait got=timeout want=done"); else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (n_data_wr - b_wr !== 256) $display("FAIL wr_data_count got=%0d want=256", n_data_wr - b_wr); else n_pass++;
    n_total++;
    if (wdata_bad - b_wb !== 0) $display("FAIL wr_data_order bad=%0d want=0", wdata_bad - b_wb); else n_pass++;
    n_total++;
    if (n_bufrd - b_rd !== 256) $display("FAIL wr_bufrd_count got=%0d want=256", n_bufrd - b_rd); else n_pass++;
    n_total++;
    if (n_bufwr - b_bw !== 0) $display("FAIL wr_no_bufwr got=%0d want=0", n_bufwr - b_bw); else n_pass++;
    n_total++;
    if (last_reg[5'h17] !== 8'h30) $display("FAIL wr_command got=%h want=30", last_reg[5'h17]); else n_pass++;
    n_total++;
    if (last_reg[5'h16] !== 8'h45) $display("FAIL wr_drvhead got=%h want=45", last_reg[5'h16]); else n_pass++;
    n_total++;
    if (error !== 1'b0 || excl_bad - b_ex !== 0) $display("FAIL wr_err_excl got=%b/%0d want=0/0", error, excl_bad - b_ex); else n_pass++;
  endtask

  task automatic test_param_err();
    logic [7:0] cnts [3];
    logic       rds  [3];
    int b_acc, b_done, cyc;
    bit ok;
    cnts[0] = 8'd0; cnts[1] = 8'(MAX_SECT + 1); cnts[2] = 8'd1;
    rds[0]  = 1'b0; rds[1]  = 1'b0;            rds[2]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_acc = n_acc; b_done = n_done;
      start_req(1'b1, rds[i], 28'h0000010, cnts[i]);
      wait_done(20, ok, cyc);
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if (!ok || n_done - b_done !== 1) $display("FAIL param_done[%0d] got=%0d want=1", i, n_done - b_done); else n_pass++;
      n_total++;
      if (error !== 1'b1 || err_code !== 3'd1) $display("FAIL param_code[%0d] got=%b/%0d want=1/1", i, error, err_code); else n_pass++;
      n_total++;
      if (n_acc - b_acc !== 0) $display("FAIL param_no_access[%0d] got=%0d want=0", i, n_acc - b_acc); else n_pass++;
    end
  endtask

  task automatic test_drq_err();
    int b_rd, b_done, cyc;
    bit ok;
    inject_err = 1'b1;
    b_rd = n_data_rd; b_done = n_done;
    start_req(1'b1, 1'b0, 28'h0000200, 8'd3);
    n_total++;
    if (error !== 1'b0 || err_code !== 3'd0) $display("FAIL drq_err_cleared got=%b/%0d want=0/0", error, err_code); else n_pass++;
    wait_done(20000, ok, cyc);
    repeat (20) @(negedge clk);
    #1;
    inject_err = 1'b0;
    n_total++;
    if (!ok || n_done - b_done !== 1) $display("FAIL drq_done got=%0d want=1", n_done - b_done); else n_pass++;
    n_total++;
    if (error !== 1'b1 || err_code !== 3'd2) $display("FAIL drq_code got=%b/%0d want=1/2", error, err_code); else n_pass++;
    n_total++;
    if (n_data_rd - b_rd !== 256) $display("FAIL drq_data_reads got=%0d want=256", n_data_rd - b_rd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [53:0] outv;
    int b_bw, b_bwa, b_wr, cyc;
    bit ok;
    b_bw = n_bufwr;
    start_req(1'b1, 1'b0, 28'h0000300, 8'd2);
    cyc = 0;
    while ((n_bufwr - b_bw) < 37 && cyc < 5000) begin @(negedge clk); #1; cyc++; end
    n_total++;
    if ((n_bufwr - b_bw) < 37) $display("FAIL rst_reach_word37 got=%0d want=37", n_bufwr - b_bw); else n_pass++;
    #1 reset = 1'b0;
    #1;
    outv = {busy, done, error, err_code, buffer_addr, buffer_rd, buffer_wr,
            buffer_out, ata_rd, ata_wr, ata_addr, ata_in};
    n_total++;
    if (outv !== '0) $display("FAIL rst_mid_outputs got=%h want=0", outv); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    b_bw = n_bufwr; b_bwa = bw_addr_bad; b_wr = n_data_wr;
    start_req(1'b1, 1'b0, 28'h0000400, 8'd1);
    // a request while busy must be ignored
    repeat (5) @(negedge clk);
    sect_cnt = 8'd0; write_req = 1'b1;
    @(negedge clk);
    write_req = 1'b0;
    wait_done(20000, ok, cyc);
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (!ok || n_bufwr - b_bw !== 256) $display("FAIL rst_new_read got=%0d want=256", n_bufwr - b_bw); else n_pass++;
    n_total++;
    if (bw_addr_bad - b_bwa !== 0) $display("FAIL rst_new_addr bad=%0d want=0", bw_addr_bad - b_bwa); else n_pass++;
    n_total++;
    if (error !== 1'b0 || n_data_wr - b_wr !== 0 || busy !== 1'b0)
      $display("FAIL busy_ignore got=%b/%0d/%b want=0/0/0", error, n_data_wr - b_wr, busy);
    else n_pass++;
  endtask

`ifdef IDE_DISK_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    bit ok;
    stuck_bsy = 1'b1;
    start_req(1'b1, 1'b0, 28'h0000001, 8'd1);
    wait_done(1000, ok, cyc);
    repeat (2) @(negedge clk);
    stuck_bsy = 1'b0;
    n_total++;
    if (!ok || cyc !== 100) $display("FAIL tmo_latency got=%0d want=100", cyc); else n_pass++;
    n_total++;
    if (error !== 1'b1 || err_code !== 3'd3) $display("FAIL tmo_code got=%b/%0d want=1/3", error, err_code); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_read2();
    test_write1();
    test_param_err();
    test_drq_err();
    test_reset_mid();
`ifdef IDE_DISK_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
